// File: rtl/trap_controller.sv
// User-mode trap sequencer: saves uepc/ucause/utval/ustatus, redirects the PC,
// handles uret and ebreak halt/resume.
module trap_controller #(
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iEcall,
  input  logic        iEbreak,
  input  logic        iInvInstruction,
  input  logic        iUret,
  input  logic        iExtIrq,
  input  logic [31:0] iPC,
  input  logic [31:0] iInstr,
  input  logic [31:0] iUstatus,
  input  logic [31:0] iUtvec,
  input  logic [31:0] iUepc,
  input  logic        iResume,
  output logic        oStall,
  output logic        oCSRWe,
  output logic [11:0] oCSRAddr,
  output logic [31:0] oCSRData,
  output logic        oPCLoad,
  output logic [31:0] oPCValue,
  output logic        oHalted
);

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_TVAL,
    S_STATUS,
    S_JUMP,
    RET,
    HALT
  } state_e;

  localparam logic [31:0] CAUSE_ILL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL = 32'd8;
  localparam logic [31:0] CAUSE_IRQ = 32'h8000_0008;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;

  logic take_ill;
  logic take_ebrk;
  logic take_ecall;
  logic take_uret;
  logic take_irq;
  logic any_req;

  // One-hot after priority resolution, so the decoder below can be unique.
  always_comb begin
    take_ill   = iInvInstruction;
    take_ebrk  = iEbreak & ~iInvInstruction;
    take_ecall = iEcall & ~iEbreak & ~iInvInstruction;
    take_uret  = iUret & ~iEcall & ~iEbreak & ~iInvInstruction;
    take_irq   = iExtIrq & iUstatus[0] & ~iUret & ~iEcall
               & ~iEbreak & ~iInvInstruction;
    any_req    = take_ill | take_ebrk | take_ecall
               | take_uret | take_irq;
  end

  logic [31:0] tvec_base;
  logic        vec_hit;
  logic [31:0] jump_pc;

  always_comb begin
    tvec_base = {iUtvec[31:2], 2'b00};
    vec_hit   = (VECTORED_EN != 0) && (iUtvec[1:0] == 2'b01)
              && cause_q[31];
    jump_pc   = vec_hit ? tvec_base + 32'd32 : tvec_base;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            take_ill: begin
              pc_q    <= iPC;
              cause_q <= CAUSE_ILL;
              tval_q  <= iInstr;
              state_q <= S_EPC;
            end
            take_ebrk: begin
              pc_q    <= iPC;
              state_q <= HALT;
            end
            take_ecall: begin
              pc_q    <= iPC;
              cause_q <= CAUSE_ECALL;
              tval_q  <= '0;
              state_q <= S_EPC;
            end
            take_uret: state_q <= RET;
            take_irq: begin
              pc_q    <= iPC;
              cause_q <= CAUSE_IRQ;
              tval_q  <= '0;
              state_q <= S_EPC;
            end
            default: state_q <= IDLE;
          endcase
        end
        S_EPC:    state_q <= S_CAUSE;
        S_CAUSE:  state_q <= S_TVAL;
        S_TVAL:   state_q <= S_STATUS;
        S_STATUS: state_q <= S_JUMP;
        S_JUMP:   state_q <= IDLE;
        RET:      state_q <= IDLE;
        HALT:     if (iResume) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    oStall   = 1'b0;
    oCSRWe   = 1'b0;
    oCSRAddr = '0;
    oCSRData = '0;
    oPCLoad  = 1'b0;
    oPCValue = '0;
    oHalted  = 1'b0;
    unique case (state_q)
      IDLE: oStall = any_req & iRST_n;
      S_EPC: begin
        oStall   = 1'b1;
        oCSRWe   = 1'b1;
        oCSRAddr = 12'h041;
        oCSRData = pc_q;
      end
      S_CAUSE: begin
        oStall   = 1'b1;
        oCSRWe   = 1'b1;
        oCSRAddr = 12'h042;
        oCSRData = cause_q;
      end
      S_TVAL: begin
        oStall   = 1'b1;
        oCSRWe   = 1'b1;
        oCSRAddr = 12'h043;
        oCSRData = tval_q;
      end
      S_STATUS: begin
        oStall   = 1'b1;
        oCSRWe   = 1'b1;
        oCSRAddr = 12'h000;
        oCSRData = {iUstatus[31:5], iUstatus[0],
                    iUstatus[3:1], 1'b0};
      end
      S_JUMP: begin
        oStall   = 1'b1;
        oPCLoad  = 1'b1;
        oPCValue = jump_pc;
      end
      RET: begin
        oStall   = 1'b1;
        oCSRWe   = 1'b1;
        oCSRAddr = 12'h000;
        oCSRData = {iUstatus[31:5], 1'b1,
                    iUstatus[3:1], iUstatus[4]};
        oPCLoad  = 1'b1;
        oPCValue = iUepc;
      end
      HALT: begin
        oStall  = 1'b1;
        oHalted = 1'b1;
        if (iResume) begin
          oPCLoad  = 1'b1;
          oPCValue = pc_q + 32'd4;
        end
      end
      default: oStall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: per-cycle expected outputs go
// through a scoreboard queue and are checked mid-cycle.
module tb_trap_controller;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iEcall, iEbreak, iInvInstruction, iUret;
  logic        iExtIrq, iResume;
  logic [31:0] iPC, iInstr, iUstatus, iUtvec, iUepc;
  logic        oStall, oCSRWe, oPCLoad, oHalted;
  logic [11:0] oCSRAddr;
  logic [31:0] oCSRData, oPCValue;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        pl;
    logic [31:0] pv;
    logic        halt;
  } out_t;

  out_t  sb[$];
  string tags[$];
  int    errs = 0;
  int    checks = 0;

  trap_controller dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iEcall(iEcall), .iEbreak(iEbreak),
    .iInvInstruction(iInvInstruction), .iUret(iUret),
    .iExtIrq(iExtIrq), .iPC(iPC), .iInstr(iInstr),
    .iUstatus(iUstatus), .iUtvec(iUtvec), .iUepc(iUepc),
    .iResume(iResume), .oStall(oStall), .oCSRWe(oCSRWe),
    .oCSRAddr(oCSRAddr), .oCSRData(oCSRData),
    .oPCLoad(oPCLoad), .oPCValue(oPCValue), .oHalted(oHalted)
  );

  always #5 iCLK = ~iCLK;

  function automatic out_t mk(input logic st, input logic we,
                              input logic [11:0] a,
                              input logic [31:0] d, input logic pl,
                              input logic [31:0] pv, input logic h);
    out_t o;
    o.stall = st; o.we = we; o.addr = a; o.data = d;
    o.pl = pl; o.pv = pv; o.halt = h;
    return o;
  endfunction

  function automatic out_t z();
    return mk(0, 0, 12'h0, 32'h0, 0, 32'h0, 0);
  endfunction

  function automatic out_t stl();
    return mk(1, 0, 12'h0, 32'h0, 0, 32'h0, 0);
  endfunction

  function automatic out_t wr(input logic [11:0] a,
                              input logic [31:0] d);
    return mk(1, 1, a, d, 0, 32'h0, 0);
  endfunction

  function automatic out_t jmp(input logic [31:0] pv);
    return mk(1, 0, 12'h0, 32'h0, 1, pv, 0);
  endfunction

  task automatic step(input string tag, input out_t e);
    out_t obs, exp_v;
    string t;
    sb.push_back(e);
    tags.push_back(tag);
    @(negedge iCLK);
    obs = mk(oStall, oCSRWe, oCSRAddr, oCSRData,
             oPCLoad, oPCValue, oHalted);
    exp_v = sb.pop_front();
    t = tags.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp_v);
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic clr();
    iEcall = 0; iEbreak = 0; iInvInstruction = 0;
    iUret = 0; iExtIrq = 0; iResume = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr();
    iRST_n = 0; iPC = 0; iInstr = 0;
    iUstatus = 0; iUtvec = 0; iUepc = 0;
    @(posedge iCLK); #1;
    iEcall = 1;
    step("reset_outputs", z());
    clr();
    iRST_n = 1;
    step("idle_quiet", z());

    // ecall, direct mode
    iPC = 32'h0040_0010; iUtvec = 32'h0040_0200; iUstatus = 32'h1;
    iEcall = 1;
    step("ecall_detect", stl());
    iEcall = 0;
    step("ecall_uepc", wr(12'h041, 32'h0040_0010));
    step("ecall_ucause", wr(12'h042, 32'h8));
    step("ecall_utval", wr(12'h043, 32'h0));
    step("ecall_ustatus", wr(12'h000, 32'h10));
    step("ecall_jump", jmp(32'h0040_0200));
    step("ecall_idle", z());

    // illegal beats ecall; vectored bits ignored for exceptions
    iPC = 32'h0040_0020; iInstr = 32'hFFFF_FFFF;
    iUtvec = 32'h0040_0201;
    iInvInstruction = 1; iEcall = 1;
    step("ill_detect", stl());
    clr();
    step("ill_uepc", wr(12'h041, 32'h0040_0020));
    step("ill_ucause", wr(12'h042, 32'h2));
    step("ill_utval", wr(12'h043, 32'hFFFF_FFFF));
    step("ill_ustatus", wr(12'h000, 32'h10));
    step("ill_jump", jmp(32'h0040_0200));
    step("ill_idle", z());

    // masked interrupt
    iUstatus = 32'h0; iExtIrq = 1;
    step("irq_masked", z());
    clr();

    // vectored interrupt; mid-sequence requests ignored
    iUstatus = 32'h1; iPC = 32'h0040_0030; iExtIrq = 1;
    step("virq_detect", stl());
    iExtIrq = 0;
    step("virq_uepc", wr(12'h041, 32'h0040_0030));
    iEcall = 1;
    step("virq_ucause", wr(12'h042, 32'h8000_0008));
    iEcall = 0;
    step("virq_utval", wr(12'h043, 32'h0));
    step("virq_ustatus", wr(12'h000, 32'h10));
    step("virq_jump", jmp(32'h0040_0220));
    step("virq_idle", z());

    // uret then pending interrupt
    iUtvec = 32'h0040_0200; iUstatus = 32'h10;
    iUepc = 32'h0040_0014; iPC = 32'h0040_0050;
    iUret = 1; iExtIrq = 1;
    step("uret_detect", stl());
    iUret = 0;
    step("uret_ret", mk(1, 1, 12'h000, 32'h11, 1,
                        32'h0040_0014, 0));
    iUstatus = 32'h11; iPC = 32'h0040_0014;
    step("uret_irq_detect", stl());
    iExtIrq = 0;
    step("uret_irq_uepc", wr(12'h041, 32'h0040_0014));
    step("uret_irq_ucause", wr(12'h042, 32'h8000_0008));
    step("uret_irq_utval", wr(12'h043, 32'h0));
    step("uret_irq_ustatus", wr(12'h000, 32'h10));
    step("uret_irq_jump", jmp(32'h0040_0200));
    step("uret_irq_idle", z());

    // ebreak halt, irq ignored, resume
    iUstatus = 32'h1; iPC = 32'h0040_0008; iEbreak = 1;
    step("ebrk_detect", stl());
    iEbreak = 0; iExtIrq = 1; iPC = 32'h0040_0100;
    step("ebrk_halt1", mk(1, 0, 12'h0, 32'h0, 0, 32'h0, 1));
    step("ebrk_halt2", mk(1, 0, 12'h0, 32'h0, 0, 32'h0, 1));
    iExtIrq = 0; iResume = 1;
    step("ebrk_resume", mk(1, 0, 12'h0, 32'h0, 1,
                           32'h0040_000C, 1));
    step("resume_in_idle", z());
    iResume = 0;

    // reset during S_CAUSE aborts the sequence
    iPC = 32'h0040_0040; iEcall = 1;
    step("rst_detect", stl());
    iEcall = 0;
    step("rst_uepc", wr(12'h041, 32'h0040_0040));
    iRST_n = 0;
    step("rst_in_cause", z());
    step("rst_held", z());
    iRST_n = 1;
    for (int i = 0; i < 4; i++) step("rst_after", z());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
